// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle processor.
// Sequences fetch/decode/exec/mem/wb and counts retired instructions.
module multicycle_control #(
    parameter int WIDTH_OPCODE      = 5,
    parameter int REGFILE_ADDR_BITS = 2,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH_OPCODE-1:0]      opcode,
    input  logic [REGFILE_ADDR_BITS-1:0] reg_dest,
    input  logic                         mem_ready,
    input  logic                         alu_done,
    input  logic                         cmp_eq,
    input  logic                         cmp_lt,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic                         iord,
    output logic                         ir_write,
    output logic                         pc_write,
    output logic                         pc_src,
    output logic [2:0]                   alu_op,
    output logic                         alu_src_imm,
    output logic                         alu_start,
    output logic                         reg_write,
    output logic                         mem_to_reg,
    output logic                         illegal_op,
    output logic [COUNT_WIDTH-1:0]       instret,
    output logic [2:0]                   state
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        ALU_WAIT = 3'd3,
        MEM_RD   = 3'd4,
        MEM_WR   = 3'd5,
        WB       = 3'd6
    } state_t;

    localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(0);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(1);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(2);
    localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(3);
    localparam logic [WIDTH_OPCODE-1:0] OP_MULT = WIDTH_OPCODE'(5);
    localparam logic [WIDTH_OPCODE-1:0] OP_DIV  = WIDTH_OPCODE'(7);
    localparam logic [WIDTH_OPCODE-1:0] OP_LR   = WIDTH_OPCODE'(8);
    localparam logic [WIDTH_OPCODE-1:0] OP_SR   = WIDTH_OPCODE'(9);
    localparam logic [WIDTH_OPCODE-1:0] OP_BLEQ = WIDTH_OPCODE'(13);
    localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(14);
    localparam logic [WIDTH_OPCODE-1:0] OP_BEQ  = WIDTH_OPCODE'(18);
    localparam logic [WIDTH_OPCODE-1:0] OP_BNEQ = WIDTH_OPCODE'(19);
    localparam logic [WIDTH_OPCODE-1:0] OP_BGEQ = WIDTH_OPCODE'(22);
    localparam logic [WIDTH_OPCODE-1:0] OP_BGT  = WIDTH_OPCODE'(23);
    localparam logic [WIDTH_OPCODE-1:0] OP_MOV  = WIDTH_OPCODE'(27);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_MUL  = 3'd3;
    localparam logic [2:0] ALU_DIV  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;

    state_t     cur, nxt;
    logic       retire;
    logic       is_alu, is_addi, is_md, is_mem, is_br, is_nop;
    logic       br_taken;
    logic [2:0] ex_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur     <= FETCH;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                instret <= instret + COUNT_WIDTH'(1);
        end
    end

    assign state = cur;

    // Opcode classification; unsupported opcodes leave every flag low.
    always_comb begin
        is_alu   = 1'b0;
        is_addi  = 1'b0;
        is_md    = 1'b0;
        is_mem   = 1'b0;
        is_br    = 1'b0;
        is_nop   = 1'b0;
        br_taken = 1'b0;
        ex_op    = ALU_ADD;
        case (opcode)
            OP_NOP:  is_nop = 1'b1;
            OP_ADD:  is_alu = 1'b1;
            OP_SUB:  begin is_alu = 1'b1; ex_op = ALU_SUB;  end
            OP_AND:  begin is_alu = 1'b1; ex_op = ALU_AND;  end
            OP_MOV:  begin is_alu = 1'b1; ex_op = ALU_PASS; end
            OP_ADDI: is_addi = 1'b1;
            OP_MULT: begin is_md = 1'b1; ex_op = ALU_MUL; end
            OP_DIV:  begin is_md = 1'b1; ex_op = ALU_DIV; end
            OP_LR:   is_mem = 1'b1;
            OP_SR:   is_mem = 1'b1;
            OP_BLEQ: begin is_br = 1'b1; br_taken = cmp_lt | cmp_eq;   end
            OP_BEQ:  begin is_br = 1'b1; br_taken = cmp_eq;            end
            OP_BNEQ: begin is_br = 1'b1; br_taken = !cmp_eq;           end
            OP_BGEQ: begin is_br = 1'b1; br_taken = !cmp_lt;           end
            OP_BGT:  begin is_br = 1'b1; br_taken = !cmp_lt && !cmp_eq; end
            default: ;
        endcase
    end

    always_comb begin
        nxt         = cur;
        retire      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        alu_start   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_op  = 1'b0;
        unique case (cur)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: nxt = EXEC;
            EXEC: begin
                unique case (1'b1)
                    is_alu: begin
                        alu_op = ex_op;
                        nxt    = WB;
                    end
                    is_addi: begin
                        alu_src_imm = 1'b1;
                        nxt         = WB;
                    end
                    is_md: begin
                        alu_op    = ex_op;
                        alu_start = 1'b1;
                        nxt       = alu_done ? WB : ALU_WAIT;
                    end
                    is_mem: begin
                        alu_src_imm = 1'b1;
                        nxt = (opcode == OP_LR) ? MEM_RD : MEM_WR;
                    end
                    is_br: begin
                        alu_op   = ALU_SUB;
                        pc_write = br_taken;
                        pc_src   = br_taken;
                        retire   = 1'b1;
                        nxt      = FETCH;
                    end
                    is_nop: begin
                        retire = 1'b1;
                        nxt    = FETCH;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = FETCH;
                    end
                endcase
            end
            // Remainder of a multi-cycle EXEC; the start pulse is not repeated.
            ALU_WAIT: begin
                alu_op = ex_op;
                if (alu_done)
                    nxt = WB;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)
                    nxt = WB;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    nxt    = FETCH;
                end
            end
            WB: begin
                reg_write  = (reg_dest != '0);
                mem_to_reg = (opcode == OP_LR);
                retire     = 1'b1;
                nxt        = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Expected output vectors are hand-written per cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode;
    logic [1:0]  reg_dest;
    logic        mem_ready, alu_done, cmp_eq, cmp_lt;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src;
    logic [2:0]  alu_op;
    logic        alu_src_imm, alu_start, reg_write, mem_to_reg, illegal_op;
    logic [15:0] instret;
    logic [2:0]  state;

    int nchk = 0;
    int nfail = 0;
    int exp_ret = 0;

    logic [16:0] obs, f_rdy, f_wait, dec;

    always #5 clk = ~clk;

    multicycle_control #(
        .WIDTH_OPCODE(5),
        .REGFILE_ADDR_BITS(2),
        .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .reg_dest(reg_dest),
        .mem_ready(mem_ready), .alu_done(alu_done),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_start(alu_start),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .instret(instret), .state(state)
    );

    assign obs = {state, mem_read, mem_write, iord, ir_write, pc_write,
                  pc_src, alu_op, alu_src_imm, alu_start, reg_write,
                  mem_to_reg, illegal_op};

    // State encoding: 0 FETCH, 1 DECODE, 2 EXEC, 3 EXEC wait,
    // 4 MEM read, 5 MEM write, 6 WB.
    function automatic logic [16:0] ev(
        input logic [2:0] st, input logic mr, mw, io, irw, pcw, pcs,
        input logic [2:0] op, input logic imm, stt, rw, m2r, ill);
        return {st, mr, mw, io, irw, pcw, pcs, op, imm, stt, rw, m2r, ill};
    endfunction

    task automatic set_ir(input logic [18:0] ir);
        opcode   = ir[18:14];
        reg_dest = ir[13:12];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        alu_done = 1'b1;
        repeat (3) @(negedge clk);
        alu_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        nchk++;
        if (obs !== f_wait) begin
            nfail++;
            $display("FAIL reset_outputs: got %h want %h", obs, f_wait);
        end
        nchk++;
        if (instret !== 16'd0) begin
            nfail++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
        exp_ret = 0;
    endtask

    task automatic test_lr();
        logic [16:0] ex [5];
        ex = '{f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 1,0,0,0,0),
               ev(4, 1,0,1,0,0,0, 0, 0,0,0,0,0),
               ev(6, 0,0,0,0,0,0, 0, 0,0,1,1,0)};
        set_ir(19'h21010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL lr c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        exp_ret++;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nchk++;
        if (obs !== f_wait || instret !== exp_ret[15:0]) begin
            nfail++;
            $display("FAIL lr_retire: got %h/%0d want %h/%0d",
                     obs, instret, f_wait, exp_ret);
        end
    endtask

    task automatic test_add_wait();
        logic [16:0] ex [7];
        logic [6:0]  rdy;
        int          irw_cnt;
        ex = '{f_wait, f_wait, f_wait, f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 0,0,0,0,0),
               ev(6, 0,0,0,0,0,0, 0, 0,0,1,0,0)};
        rdy = 7'b1111000;
        irw_cnt = 0;
        set_ir(19'h07600);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_ready = rdy[i];
            #1;
            if (ir_write) irw_cnt++;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL add_wait c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        exp_ret++;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nchk++;
        if (irw_cnt !== 1 || instret !== exp_ret[15:0]) begin
            nfail++;
            $display("FAIL add_wait_count: got irw=%0d ret=%0d want 1/%0d",
                     irw_cnt, instret, exp_ret);
        end
    endtask

    task automatic test_branch();
        // {opcode, eq, lt, taken}
        logic [7:0] tv [11];
        logic [16:0] ex;
        tv = '{{5'd13, 3'b011}, {5'd13, 3'b000}, {5'd13, 3'b101},
               {5'd23, 3'b001}, {5'd23, 3'b100}, {5'd23, 3'b010},
               {5'd19, 3'b100}, {5'd19, 3'b001}, {5'd18, 3'b101},
               {5'd22, 3'b010}, {5'd22, 3'b001}};
        for (int v = 0; v < 11; v++) begin
            opcode   = tv[v][7:3];
            reg_dest = 2'd3;
            cmp_eq   = tv[v][2];
            cmp_lt   = tv[v][1];
            ex = ev(2, 0,0,0,0, tv[v][0], tv[v][0], 1, 0,0,0,0,0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                mem_ready = 1'b1;
                #1;
                if (i == 2) begin
                    nchk++;
                    if (obs !== ex) begin
                        nfail++;
                        $display("FAIL branch v%0d op%0d: got %h want %h",
                                 v, opcode, obs, ex);
                    end
                end
            end
            exp_ret++;
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            nchk++;
            if (obs !== f_wait || instret !== exp_ret[15:0]) begin
                nfail++;
                $display("FAIL branch_retire v%0d: got %h/%0d want %h/%0d",
                         v, obs, instret, f_wait, exp_ret);
            end
        end
        cmp_eq = 1'b0;
        cmp_lt = 1'b0;
    endtask

    task automatic test_mult();
        logic [16:0] ex [7];
        logic [6:0]  done;
        int          starts;
        ex = '{f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 3, 0,1,0,0,0),
               ev(3, 0,0,0,0,0,0, 3, 0,0,0,0,0),
               ev(3, 0,0,0,0,0,0, 3, 0,0,0,0,0),
               ev(3, 0,0,0,0,0,0, 3, 0,0,0,0,0),
               ev(6, 0,0,0,0,0,0, 0, 0,0,1,0,0)};
        done = 7'b0100010;
        starts = 0;
        set_ir(19'h17500);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            alu_done  = done[i];
            #1;
            if (alu_start) starts++;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL mult c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        exp_ret++;
        @(negedge clk);
        mem_ready = 1'b0;
        alu_done  = 1'b0;
        #1;
        nchk++;
        if (starts !== 1 || instret !== exp_ret[15:0]) begin
            nfail++;
            $display("FAIL mult_count: got start=%0d ret=%0d want 1/%0d",
                     starts, instret, exp_ret);
        end
    endtask

    task automatic test_div_fast();
        logic [16:0] ex [4];
        ex = '{f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 4, 0,1,0,0,0),
               ev(6, 0,0,0,0,0,0, 0, 0,0,1,0,0)};
        opcode   = 5'd7;
        reg_dest = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            alu_done  = (i == 2);
            #1;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL div_fast c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        alu_done = 1'b0;
        exp_ret++;
    endtask

    task automatic test_addi_illegal();
        logic [16:0] ex [7];
        logic [4:0]  ops [7];
        ex = '{f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 1,0,0,0,0),
               ev(6, 0,0,0,0,0,0, 0, 0,0,0,0,0),
               f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 0,0,0,0,1)};
        ops = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd31, 5'd31, 5'd31};
        reg_dest = 2'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            opcode    = ops[i];
            mem_ready = 1'b1;
            #1;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL addi_ill c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        exp_ret++;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nchk++;
        if (obs !== f_wait || instret !== exp_ret[15:0]) begin
            nfail++;
            $display("FAIL addi_ill_retire: got %h/%0d want %h/%0d",
                     obs, instret, f_wait, exp_ret);
        end
    endtask

    task automatic test_nop_sr();
        logic [16:0] ex [7];
        logic [6:0]  rdy;
        ex = '{f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 0,0,0,0,0),
               f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 1,0,0,0,0),
               ev(5, 0,1,1,0,0,0, 0, 0,0,0,0,0)};
        rdy = 7'b1111111;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 3) set_ir(19'h00000);
            else set_ir(19'h24830);
            mem_ready = rdy[i];
            #1;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL nop_sr c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        exp_ret += 2;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nchk++;
        if (obs !== f_wait || instret !== exp_ret[15:0]) begin
            nfail++;
            $display("FAIL nop_sr_retire: got %h/%0d want %h/%0d",
                     obs, instret, f_wait, exp_ret);
        end
    endtask

    task automatic test_sr_reset();
        logic [16:0] ex [5];
        logic [4:0]  rdy;
        ex = '{f_rdy, dec,
               ev(2, 0,0,0,0,0,0, 0, 1,0,0,0,0),
               ev(5, 0,1,1,0,0,0, 0, 0,0,0,0,0),
               ev(5, 0,1,1,0,0,0, 0, 0,0,0,0,0)};
        rdy = 5'b00111;
        set_ir(19'h24830);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = rdy[i];
            #1;
            nchk++;
            if (obs !== ex[i]) begin
                nfail++;
                $display("FAIL sr_rst c%0d: got %h want %h", i, obs, ex[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 0;
        #1;
        nchk++;
        if (obs !== f_wait || instret !== 16'd0) begin
            nfail++;
            $display("FAIL sr_rst_after: got %h/%0d want %h/0",
                     obs, instret, f_wait);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 5'd0;
        reg_dest  = 2'd0;
        mem_ready = 1'b0;
        alu_done  = 1'b0;
        cmp_eq    = 1'b0;
        cmp_lt    = 1'b0;
        f_rdy  = ev(0, 1,0,0,1,1,0, 0, 0,0,0,0,0);
        f_wait = ev(0, 1,0,0,0,0,0, 0, 0,0,0,0,0);
        dec    = ev(1, 0,0,0,0,0,0, 0, 0,0,0,0,0);
        test_reset();
        test_lr();
        test_add_wait();
        test_branch();
        test_mult();
        test_div_fast();
        test_addi_illegal();
        test_nop_sr();
        test_sr_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
